// File: rtl/gate_sweep_ctrl_if.sv
// Bundle of the signals between the gate sweep sequencer and its environment.
//   start           : request a sweep (environment -> sequencer)
//   a_o, b_o        : vector driven to the gate block (sequencer -> gate block)
//   y_i             : 7-bit gate block response (gate block -> sequencer)
//   busy, done      : sweep status
//   pass, fail_mask, err_count, first_fail_idx, first_fail_y : sweep results
// master = the sequencer, slave = the environment (stimulus, gate block, host).
interface gate_sweep_ctrl_if;
    logic       start;
    logic       a_o;
    logic       b_o;
    logic [6:0] y_i;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_mask;
    logic [2:0] err_count;
    logic [1:0] first_fail_idx;
    logic [6:0] first_fail_y;

    modport master (
        input  start, y_i,
        output a_o, b_o, busy, done, pass, fail_mask, err_count,
               first_fail_idx, first_fail_y
    );

    modport slave (
        output start, y_i,
        input  a_o, b_o, busy, done, pass, fail_mask, err_count,
               first_fail_idx, first_fail_y
    );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer for the two-input basic-gate block.
// Steps (a,b) through 00, 01, 10, 11, holds each vector for SETTLE_CYCLES
// cycles, samples the 7-bit gate output on the last cycle of the window and
// compares it with a hardwired golden table, accumulating a per-vector
// pass/fail record.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : gate_sweep_ctrl_if.master (start, a_o, b_o, y_i, busy, done,
//          pass, fail_mask, err_count, first_fail_idx, first_fail_y)
// SETTLE_CYCLES must be in 1..255.
module gate_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    gate_sweep_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

    // Expected gate block response for vector idx = {a,b}.
    // Bit map: 0=AND 1=OR 2=NAND 3=NOR 4=XOR 5=XNOR 6=NOT a.
    function automatic logic [6:0] golden(input logic [1:0] idx);
        logic [6:0] y;
        case (idx)
            2'd0:    y = 7'h6C;
            2'd1:    y = 7'h56;
            2'd2:    y = 7'h16;
            2'd3:    y = 7'h23;
            default: y = 7'h00;
        endcase
        return y;
    endfunction

    state_t     state_r;
    logic [1:0] idx_r;
    logic [7:0] cnt_r;
    logic       a_r;
    logic       b_r;
    logic       busy_r;
    logic       done_r;
    logic       pass_r;
    logic [3:0] fail_mask_r;
    logic [2:0] err_count_r;
    logic [1:0] first_fail_idx_r;
    logic [6:0] first_fail_y_r;

    logic [6:0] golden_s;
    logic       match_s;
    logic       sample_s;
    logic [1:0] next_idx_s;

    // Compare against golden; an unknown compare result falls to the else
    // branch so X/Z on y_i is reported as a mismatch.
    always_comb begin
        golden_s   = golden(idx_r);
        sample_s   = (cnt_r == LAST_CNT);
        next_idx_s = idx_r + 2'd1;
        if (bus.y_i == golden_s) begin
            match_s = 1'b1;
        end else begin
            match_s = 1'b0;
        end
    end

    // Sweep FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= IDLE;
            idx_r            <= 2'd0;
            cnt_r            <= 8'd0;
            a_r              <= 1'b0;
            b_r              <= 1'b0;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            pass_r           <= 1'b0;
            fail_mask_r      <= 4'd0;
            err_count_r      <= 3'd0;
            first_fail_idx_r <= 2'd0;
            first_fail_y_r   <= 7'd0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    // DONE restarts directly, without passing through IDLE.
                    if (bus.start) begin
                        state_r          <= RUN;
                        idx_r            <= 2'd0;
                        cnt_r            <= 8'd0;
                        a_r              <= 1'b0;
                        b_r              <= 1'b0;
                        busy_r           <= 1'b1;
                        done_r           <= 1'b0;
                        pass_r           <= 1'b0;
                        fail_mask_r      <= 4'd0;
                        err_count_r      <= 3'd0;
                        first_fail_idx_r <= 2'd0;
                        first_fail_y_r   <= 7'd0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                RUN: begin
                    // start is deliberately not looked at while running.
                    if (sample_s) begin
                        if (!match_s) begin
                            fail_mask_r[idx_r] <= 1'b1;
                            err_count_r        <= err_count_r + 3'd1;
                            if (err_count_r == 3'd0) begin
                                first_fail_idx_r <= idx_r;
                                first_fail_y_r   <= bus.y_i;
                            end else begin
                                first_fail_idx_r <= first_fail_idx_r;
                            end
                        end else begin
                            err_count_r <= err_count_r;
                        end
                        if (idx_r != 2'd3) begin
                            idx_r <= next_idx_s;
                            cnt_r <= 8'd0;
                            a_r   <= next_idx_s[1];
                            b_r   <= next_idx_s[0];
                        end else begin
                            // a_o/b_o stay at 1,1 while results are held.
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            pass_r  <= (err_count_r == 3'd0) && match_s;
                        end
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a_o            = a_r;
    assign bus.b_o            = b_r;
    assign bus.busy           = busy_r;
    assign bus.done           = done_r;
    assign bus.pass           = pass_r;
    assign bus.fail_mask      = fail_mask_r;
    assign bus.err_count      = err_count_r;
    assign bus.first_fail_idx = first_fail_idx_r;
    assign bus.first_fail_y   = first_fail_y_r;

endmodule
